// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and pattern decoder, used by both the display
// driver (encoding) and the scan-capture monitor (decoding).
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] HEX_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] nibble;
  } dec_t;

  typedef struct packed {
    logic       dp;
    logic       blank;
    logic       err;
    logic [3:0] nibble;
  } digit_t;

  // All-off reads as blank; anything outside the hex table is an error (nibble 0).
  function automatic dec_t seg_decode(input logic [6:0] pat);
    dec_t d;
    d = '{err: 1'b1, blank: 1'b0, nibble: 4'h0};
    if (pat == 7'h00) begin
      d.err   = 1'b0;
      d.blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pat == HEX_PAT[i]) begin
          d.err    = 1'b0;
          d.nibble = 4'(i);
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern decoder with decimal-point passthrough.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] nibble,
  output logic       dp,
  output logic       blank,
  output logic       err
);

  dec_t d;

  assign d      = seg_decode(seg[SEG_G:SEG_A]);
  assign nibble = d.nibble;
  assign blank  = d.blank;
  assign err    = d.err;
  assign dp     = seg[SEG_DP];

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 7-segment bus, decodes each stable digit and emits one
// valid pulse per fully scanned 4-digit frame, with error/blank/stale flags.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE         = 4,
  parameter int TIMEOUT        = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_seg,
  input  logic [3:0]  i_dig,
  output logic [15:0] o_value,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic        o_err,
  output logic        o_valid,
  output logic        o_stale
);

  localparam int SW = $clog2(STABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [7:0]    seg_q, seg_n, seg_r;
  logic [3:0]    dig_q, dig_n, sel_r;
  logic          legal;
  logic [1:0]    state, state_nx;
  logic [SW-1:0] cnt, cnt_nx;
  logic          capture;
  logic [3:0]    dec_nib;
  logic          dec_dp, dec_blank, dec_err;
  logic [3:0]    seen;
  logic [TW-1:0] tmo;
  logic          frame_done, err_any;
  digit_t        shadow [4];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      seg_q <= '0;
      dig_q <= '0;
    end else begin
      seg_q <= i_seg;
      dig_q <= i_dig;
    end
  end

  // Internally 1 always means lit / selected.
  assign seg_n = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dig_n = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
  assign legal = (dig_n != 4'b0) && ((dig_n & (dig_n - 4'd1)) == 4'b0);

  seg7_decode u_decode (
    .seg    (seg_n),
    .nibble (dec_nib),
    .dp     (dec_dp),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          state_nx = SETTLE;
          cnt_nx   = SW'(1);
        end
      end
      SETTLE: begin
        if (!legal) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (dig_n != sel_r || seg_n != seg_r) begin
          cnt_nx = SW'(1);
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!legal) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (dig_n != sel_r) begin
          state_nx = SETTLE;
          cnt_nx   = SW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    if (state_nx == SETTLE && cnt_nx == SW'(STABLE)) begin
      capture  = 1'b1;
      state_nx = HOLD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel_r <= '0;
      seg_r <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sel_r <= dig_n;
      seg_r <= seg_n;
    end
  end

  assign frame_done = (seen == 4'hF);
  assign err_any    = shadow[0].err | shadow[1].err | shadow[2].err | shadow[3].err;
  assign o_stale    = (tmo == TW'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      seen    <= '0;
      tmo     <= '0;
      o_value <= '0;
      o_dp    <= '0;
      o_blank <= '0;
      o_err   <= 1'b0;
      o_valid <= 1'b0;
      // NOTE: the four shadow entries are small flops, so clearing them on reset is cheap and keeps readback deterministic.
      for (int k = 0; k < 4; k++) shadow[k] <= '0;
    end else begin
      o_valid <= frame_done;
      seen    <= (frame_done ? 4'b0 : seen) | (capture ? dig_n : 4'b0);
      if (frame_done) begin
        tmo   <= '0;
        o_err <= err_any;
        for (int k = 0; k < 4; k++) begin
          o_value[4*k +: 4] <= shadow[k].nibble;
          o_dp[k]           <= shadow[k].dp;
          o_blank[k]        <= shadow[k].blank;
        end
      end else if (!o_stale) begin
        tmo <= tmo + 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        if (capture && dig_n[k])
          shadow[k] <= '{dp: dec_dp, blank: dec_blank, err: dec_err, nibble: dec_nib};
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed and randomized scans against a dwell-level reference model; an
// active-high and an active-low instance see the same logical stimulus.
module tb_seg7_scan_capture;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 60;
  localparam int MAXC    = 2048;

  typedef struct {
    logic [3:0] dig;
    logic [7:0] seg;
    int         len;
  } dwell_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg, seg_l;
  logic [3:0]  dig, dig_l;
  logic [15:0] value_h, value_l;
  logic [3:0]  dp_h, dp_l, blank_h, blank_l;
  logic        err_h, err_l, valid_h, valid_l, stale_h, stale_l;

  always #5 clk = ~clk;

  seg7_scan_capture #(.STABLE(STABLE), .TIMEOUT(TIMEOUT),
                      .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_h (
    .i_clk(clk), .i_rst(rst), .i_seg(seg), .i_dig(dig),
    .o_value(value_h), .o_dp(dp_h), .o_blank(blank_h), .o_err(err_h),
    .o_valid(valid_h), .o_stale(stale_h));

  seg7_scan_capture #(.STABLE(STABLE), .TIMEOUT(TIMEOUT),
                      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_seg(seg_l), .i_dig(dig_l),
    .o_value(value_l), .o_dp(dp_l), .o_blank(blank_l), .o_err(err_l),
    .o_valid(valid_l), .o_stale(stale_l));

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  dwell_t      plan [$];
  logic        exp_valid [MAXC];
  logic        exp_stale [MAXC];
  logic        exp_err   [MAXC];
  logic [15:0] exp_value [MAXC];
  logic [3:0]  exp_dp    [MAXC];
  logic [3:0]  exp_blank [MAXC];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] n,
                                     output logic b, output logic er);
    n  = 4'h0;
    b  = (p == 7'h00);
    er = !b;
    for (int i = 0; i < 16; i++) begin
      if (hex_tab[i] == p) begin
        n  = 4'(i);
        er = 1'b0;
      end
    end
  endfunction

  task automatic add(input logic [3:0] d, input logic [7:0] s, input int len);
    dwell_t w;
    w.dig = d;
    w.seg = s;
    w.len = len;
    plan.push_back(w);
  endtask

  task automatic drive(input dwell_t w);
    dig   = w.dig;
    seg   = w.seg;
    dig_l = ~w.dig;
    seg_l = ~w.seg;
  endtask

  // Model: a digit is captured once per uninterrupted run of one legal select,
  // from the first unchanged pattern held longer than STABLE cycles; capture
  // lands STABLE edges after the pattern's first sample, and a completed set of
  // four digits is published one edge later.
  task automatic build_expect(output int total);
    int          cap_t [$];
    logic [3:0]  cap_d [$];
    logic [7:0]  cap_s [$];
    logic [3:0]  prev_sel = '0;
    bit          captured = 0;
    int          t = 0;
    int          ci = 0;
    int          last_zero = -1;
    bit          pending = 0;
    logic [3:0]  seen = '0;
    logic [3:0]  nib [4];
    logic        dpv [4], blk [4], erv [4];
    logic [15:0] h_value = '0, p_value = '0;
    logic [3:0]  h_dp = '0, h_blank = '0, p_dp = '0, p_blank = '0;
    logic        h_err = 1'b0, p_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nib[k] = '0; dpv[k] = 0; blk[k] = 0; erv[k] = 0;
    end
    foreach (plan[i]) begin
      if ($countones(plan[i].dig) == 1) begin
        if (plan[i].dig != prev_sel) captured = 0;
        if (!captured && plan[i].len > STABLE) begin
          cap_t.push_back(t + STABLE);
          cap_d.push_back(plan[i].dig);
          cap_s.push_back(plan[i].seg);
          captured = 1;
        end
        prev_sel = plan[i].dig;
      end else begin
        prev_sel = '0;
      end
      t += plan[i].len;
    end
    total = t;
    for (int e = 0; e < total; e++) begin
      bit v;
      v = pending;
      if (pending) begin
        h_value = p_value; h_dp = p_dp; h_blank = p_blank; h_err = p_err;
        last_zero = e;
        pending = 0;
      end
      if (ci < cap_t.size() && cap_t[ci] == e) begin
        for (int k = 0; k < 4; k++) begin
          if (cap_d[ci] == 4'(1 << k)) begin
            ref_decode(cap_s[ci][6:0], nib[k], blk[k], erv[k]);
            dpv[k]  = cap_s[ci][7];
            seen[k] = 1'b1;
          end
        end
        ci++;
        if (seen == 4'hF) begin
          pending = 1;
          seen    = '0;
          p_err   = 1'b0;
          for (int k = 0; k < 4; k++) begin
            p_value[4*k +: 4] = nib[k];
            p_dp[k]    = dpv[k];
            p_blank[k] = blk[k];
            p_err      = p_err | erv[k];
          end
        end
      end
      exp_valid[e] = v;
      exp_value[e] = h_value;
      exp_dp[e]    = h_dp;
      exp_blank[e] = h_blank;
      exp_err[e]   = h_err;
      exp_stale[e] = ((e - last_zero) >= TIMEOUT);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, " rst value_h"}, value_h, 16'h0);
    check({name, " rst value_l"}, value_l, 16'h0);
    check({name, " rst dp_h"}, 16'(dp_h), 16'h0);
    check({name, " rst dp_l"}, 16'(dp_l), 16'h0);
    check({name, " rst blank_h"}, 16'(blank_h), 16'h0);
    check({name, " rst blank_l"}, 16'(blank_l), 16'h0);
    check({name, " rst err_h"}, 16'(err_h), 16'h0);
    check({name, " rst err_l"}, 16'(err_l), 16'h0);
    check({name, " rst valid_h"}, 16'(valid_h), 16'h0);
    check({name, " rst valid_l"}, 16'(valid_l), 16'h0);
    check({name, " rst stale_h"}, 16'(stale_h), 16'h0);
    check({name, " rst stale_l"}, 16'(stale_l), 16'h0);
  endtask

  task automatic check_cycle(input string name, input int e);
    string c;
    c = $sformatf("%s@%0d", name, e);
    check({c, " valid_h"}, 16'(valid_h), 16'(exp_valid[e]));
    check({c, " valid_l"}, 16'(valid_l), 16'(exp_valid[e]));
    check({c, " stale_h"}, 16'(stale_h), 16'(exp_stale[e]));
    check({c, " stale_l"}, 16'(stale_l), 16'(exp_stale[e]));
    check({c, " value_h"}, value_h, exp_value[e]);
    check({c, " value_l"}, value_l, exp_value[e]);
    check({c, " dp_h"}, 16'(dp_h), 16'(exp_dp[e]));
    check({c, " dp_l"}, 16'(dp_l), 16'(exp_dp[e]));
    check({c, " blank_h"}, 16'(blank_h), 16'(exp_blank[e]));
    check({c, " blank_l"}, 16'(blank_l), 16'(exp_blank[e]));
    check({c, " err_h"}, 16'(err_h), 16'(exp_err[e]));
    check({c, " err_l"}, 16'(err_l), 16'(exp_err[e]));
  endtask

  // Starts at a falling edge: two reset cycles (pins already on the first
  // dwell), then every dwell cycle is driven and checked half a cycle later.
  task automatic run_phase(input string name);
    int total;
    int e = 0;
    build_expect(total);
    rst = 1'b0;
    drive(plan[0]);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_zero(name);
    end
    rst = 1'b1;
    foreach (plan[i]) begin
      for (int j = 0; j < plan[i].len; j++) begin
        drive(plan[i]);
        @(posedge clk);
        @(negedge clk);
        check_cycle(name, e);
        e++;
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    seg   = '0;
    dig   = '0;
    seg_l = '1;
    dig_l = '1;
    @(negedge clk);

    plan.delete();
    add(4'b0001, 8'h06, 10); add(4'b0010, 8'h5B, 10);
    add(4'b0100, 8'h4F, 10); add(4'b1000, 8'h66, 10);
    add(4'b0000, 8'h00, 6);
    run_phase("basic");
    check("basic value_h", value_h, 16'h4321);
    check("basic value_l", value_l, 16'h4321);
    check("basic err_h", 16'(err_h), 16'h0);
    check("basic blank_h", 16'(blank_h), 16'h0);

    plan.delete();
    for (int s = 0; s < 3; s++) begin
      add(4'b0001, 8'h06, 10); add(4'b0010, 8'h5B, 10);
      add(4'b0100, 8'h4F, 3);  add(4'b1000, 8'h66, 10);
    end
    add(4'b0001, 8'h06, 10); add(4'b0010, 8'h5B, 10);
    add(4'b0100, 8'h4F, 10); add(4'b1000, 8'h66, 10);
    add(4'b0000, 8'h00, 6);
    run_phase("stale");
    check("stale end stale_h", 16'(stale_h), 16'h0);
    check("stale end value_h", value_h, 16'h4321);

    plan.delete();
    add(4'b0001, 8'h3F, 10); add(4'b0010, 8'h49, 10);
    add(4'b0100, 8'h7D, 10); add(4'b1000, 8'h87, 10);
    add(4'b0000, 8'h00, 6);
    run_phase("error");
    check("error err_h", 16'(err_h), 16'h1);
    check("error value_h", value_h, 16'h7600);
    check("error dp_h", 16'(dp_h), 16'h8);
    check("error dp_l", 16'(dp_l), 16'h8);

    plan.delete();
    add(4'b0001, 8'h06, 10); add(4'b0010, 8'h5B, 10);
    add(4'b0000, 8'h4F, 6);  add(4'b0110, 8'h4F, 8);
    add(4'b0100, 8'h4F, 10); add(4'b1000, 8'h66, 10);
    add(4'b0000, 8'h00, 6);
    run_phase("illegal");
    check("illegal value_h", value_h, 16'h4321);

    plan.delete();
    add(4'b0001, 8'h06, 10); add(4'b0010, 8'h5B, 10);
    add(4'b0100, 8'h4F, 10); add(4'b1000, 8'h66, 10);
    add(4'b0001, 8'h06, 10); add(4'b0010, 8'h5B, 10);
    add(4'b0100, 8'h4F, 10); add(4'b1000, 8'h66, 2);
    run_phase("pre_reset");
    plan.delete();
    add(4'b1000, 8'h66, 10); add(4'b0001, 8'h06, 10);
    add(4'b0010, 8'h5B, 10); add(4'b0100, 8'h4F, 10);
    add(4'b0000, 8'h00, 6);
    run_phase("mid_reset");
    check("mid_reset value_h", value_h, 16'h4321);

    plan.delete();
    for (int i = 0; i < 40; i++) begin
      dwell_t d;
      int r;
      d.dig = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      if (r < 6)       d.seg = {1'($urandom_range(0, 1)), hex_tab[$urandom_range(0, 15)]};
      else if (r == 6) d.seg = {1'($urandom_range(0, 1)), 7'h00};
      else             d.seg = 8'($urandom_range(0, 255));
      d.len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, STABLE - 1))
                                          : int'($urandom_range(STABLE + 1, STABLE + 8));
      if (i > 0 && plan[$].dig == d.dig && plan[$].seg == d.seg) d.seg[7] = ~d.seg[7];
      plan.push_back(d);
    end
    add(4'b0000, 8'h00, 8);
    run_phase("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side companion to the multiplexed 7-segment display driver: samples the time-multiplexed segment/digit-select bus, decodes each segment pattern back to a hex nibble, and assembles a complete 4-digit frame. Used in loopback checks of the display path and as a display-readback monitor on the board. It emits one valid pulse per fully scanned frame, with error, blank and stale indications.

## Interface
- STABLE, 4: cycles a digit select and segment pattern must hold unchanged before capture (≥1).
- TIMEOUT, 100000: cycles without a completed frame before o_stale asserts (≥2).
- SEG_ACTIVE_LOW, 0: 1 = i_seg bits are lit when 0.
- DIG_ACTIVE_LOW, 0: 1 = i_dig bits are selected when 0.

- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_seg  in  8  segment bus, bit order {dp,g,f,e,d,c,b,a}.
- i_dig  in  4  digit select; bit 0 = least-significant digit.
- o_value  out  16  captured frame, nibble k = digit k.
- o_dp  out  4  decimal-point state per digit.
- o_blank  out  4  digit k showed all segments off (nibble reads 0).
- o_err  out  1  at least one digit in the frame had an undecodable pattern (nibble reads 0).
- o_valid  out  1  one-cycle pulse: o_value/o_dp/o_blank/o_err updated.
- o_stale  out  1  no frame completed within TIMEOUT cycles.

## Operation
- Inputs registered once. Polarity is normalised immediately afterwards, so internally 1 = lit/selected.
- Select is legal only when exactly one bit is set. Zero or multiple set bits = no selection.
- FSM states:
  - IDLE: select illegal. On a legal select, load the counter with 1 and go to SETTLE.
  - SETTLE: each cycle with the same select and same seg, increment the counter. If select or seg changes to another legal value, reload the counter with 1 and stay. If select becomes illegal, go to IDLE. When the counter reaches STABLE, capture and go to HOLD.
  - HOLD: ignore the bus until the select changes (to a different legal select → SETTLE with counter 1; illegal → IDLE). A seg change under the same select is not recaptured.
- Capture of digit k:
  - Decode seg[6:0] with the standard hex patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - 00 = blank. Any other pattern = error.
  - Store nibble, dp, blank flag and error flag in per-digit shadow registers. Set seen[k].
- Frame completes when seen becomes 4'b1111. Then shadow registers copy to the outputs, o_err = OR of the four error flags, o_valid pulses, and seen clears. Recapturing an already-seen digit overwrites its shadow entry without affecting seen.
- Timeout counter resets on every o_valid and saturates at TIMEOUT. o_stale = (counter == TIMEOUT). o_stale clears in the same cycle o_valid asserts.
- Reset (any cycle, including mid-SETTLE): FSM→IDLE, counters 0, seen 0, shadows 0. o_value=0, o_dp=0, o_blank=0, o_err=0, o_valid=0, o_stale=0.

## Timing
- Capture occurs on the cycle the internal counter reaches STABLE. The earliest capture is STABLE+1 cycles after the pattern appears at the pins (1 input register plus STABLE hold cycles).
- o_valid asserts the cycle after the capture that completes seen, and lasts exactly one cycle. o_value is stable from that cycle until the next o_valid.
- A digit dwell shorter than STABLE+1 cycles is never captured. Such a digit holds off o_valid and eventually raises o_stale.
- Capture and frame completion in the same cycle as timeout saturation: o_valid wins, and o_stale stays 0.

## Structure
- Shared package seg7_pkg: segment bit-position constants, the 16-entry hex pattern constants, and a decode function returning {err, blank, nibble}. The existing display driver uses the same constants for encoding.
- One natural sub-module: seg7_decode (combinational pattern→{err,blank,nibble}, dp passthrough), instantiated once on the registered bus.
- Counter widths are $clog2(STABLE+1) and $clog2(TIMEOUT+1).

## Test plan
- Drive digits 0..3 with patterns 06,5B,4F,66, each for 10 cycles, STABLE=4 → one o_valid, o_value=16'h4321, o_err=0, o_blank=0.
- Present digit 2 for only 3 cycles per scan, STABLE=4 → no o_valid. o_stale=1 after TIMEOUT cycles, and clears on the first good frame.
- Digit 1 shows 0x49 (illegal), dp set on digit 3 → o_err=1, nibble 1=0, o_dp=4'b1000.
- All selects low, then 4'b0110 (two bits), then legal → no capture during the illegal periods. FSM returns to IDLE, and seen is retained.
- Active-low mode (both polarity params = 1) with inverted stimulus of the first case → o_value=16'h4321.
- Reset asserted mid-SETTLE after 3 digits are seen → all outputs 0. The next full scan produces o_valid only after all 4 digits are recaptured.
